// File: rtl/rf_wport_arbiter.sv
// rf_wport_arbiter
//   Shares the single register-file write port between the in-order
//   write-back stage and an out-of-order long-latency result source.
//   Long-latency results wait in a small FIFO and drain on cycles where
//   write-back leaves the port free. A starvation counter holds write-back
//   for one cycle once the FIFO head has been denied STARVE_LIMIT times.
//   Decode can ask whether any buffered write targets a given register.
//
// Ports
//   clk, reset                     clock, asynchronous active-high reset
//   wb_we/wb_waddr/wb_wdata/wb_pc  write-back request (zero-latency path)
//   wb_hold                        port taken by FIFO; write-back must stall
//   lu_valid/lu_ready              long-latency result handshake
//   lu_waddr/lu_wdata/lu_pc        long-latency result fields
//   rf_we/rf_waddr/rf_wdata/rf_pc  register-file write port (+ trace PC)
//   qN_addr/qN_pend                pending-write lookups for rs1, rs2, rd
module rf_wport_arbiter #(
  parameter int unsigned DEPTH        = 2,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        reset,

  input  logic        wb_we,
  input  logic [4:0]  wb_waddr,
  input  logic [31:0] wb_wdata,
  input  logic [31:0] wb_pc,
  output logic        wb_hold,

  input  logic        lu_valid,
  output logic        lu_ready,
  input  logic [4:0]  lu_waddr,
  input  logic [31:0] lu_wdata,
  input  logic [31:0] lu_pc,

  output logic        rf_we,
  output logic [4:0]  rf_waddr,
  output logic [31:0] rf_wdata,
  output logic [31:0] rf_pc,

  input  logic [4:0]  q0_addr,
  input  logic [4:0]  q1_addr,
  input  logic [4:0]  q2_addr,
  output logic        q0_pend,
  output logic        q1_pend,
  output logic        q2_pend
);

  localparam int unsigned IDX_W  = $clog2(DEPTH);
  localparam int unsigned PTR_W  = IDX_W + 1;
  localparam int unsigned CNT_W  = $clog2(STARVE_LIMIT + 1);
  localparam int unsigned NQUERY = 3;

  typedef struct packed {
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic [31:0] pc;
  } lu_entry_t;

  // ---------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------
  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [CNT_W-1:0] starve_cnt_q, starve_cnt_d;
  lu_entry_t        mem_q [DEPTH];
  lu_entry_t        mem_d [DEPTH];

  // ---------------------------------------------------------------------
  // FIFO status
  // ---------------------------------------------------------------------
  logic             fifo_empty_c;
  logic             fifo_full_c;
  logic [PTR_W-1:0] occupancy_c;
  logic [IDX_W-1:0] head_idx_c;
  logic [IDX_W-1:0] tail_idx_c;
  lu_entry_t        head_entry_c;

  assign head_idx_c   = head_q[IDX_W-1:0];
  assign tail_idx_c   = tail_q[IDX_W-1:0];
  assign fifo_empty_c = (head_q == tail_q);
  assign fifo_full_c  = (head_q[PTR_W-1] != tail_q[PTR_W-1]) &&
                        (head_idx_c == tail_idx_c);
  assign occupancy_c  = PTR_W'(tail_q - head_q);
  assign head_entry_c = mem_q[head_idx_c];

  // ---------------------------------------------------------------------
  // Requests and grant
  // ---------------------------------------------------------------------
  logic wb_req_c;
  logic fifo_req_c;
  logic starved_c;
  logic fifo_grant_c;
  logic wb_grant_c;
  logic enq_c;

  // Reset gates the requests so nothing reaches the port while asserted.
  assign wb_req_c     = !reset && wb_we && (wb_waddr != 5'd0);
  assign fifo_req_c   = !reset && !fifo_empty_c;
  assign starved_c    = (starve_cnt_q == CNT_W'(STARVE_LIMIT));
  assign fifo_grant_c = fifo_req_c && (!wb_req_c || starved_c);
  assign wb_grant_c   = !fifo_grant_c && wb_req_c;

  // lu_ready comes from registered state only; x0 results are acknowledged
  // but never stored.
  assign lu_ready = !fifo_full_c;
  assign enq_c    = !reset && lu_valid && lu_ready && (lu_waddr != 5'd0);

  assign wb_hold  = fifo_grant_c && wb_req_c;

  // ---------------------------------------------------------------------
  // Write port mux
  // ---------------------------------------------------------------------
  always_comb begin
    rf_we    = 1'b0;
    rf_waddr = wb_waddr;
    rf_wdata = wb_wdata;
    rf_pc    = wb_pc;
    if (fifo_grant_c) begin
      rf_we    = 1'b1;
      rf_waddr = head_entry_c.waddr;
      rf_wdata = head_entry_c.wdata;
      rf_pc    = head_entry_c.pc;
    end else if (wb_grant_c) begin
      rf_we    = 1'b1;
    end
  end

  // ---------------------------------------------------------------------
  // Next-state: pointers, storage, starvation counter
  // ---------------------------------------------------------------------
  always_comb begin
    head_d       = head_q;
    tail_d       = tail_q;
    mem_d        = mem_q;
    starve_cnt_d = starve_cnt_q;

    if (fifo_grant_c) begin
      head_d = PTR_W'(head_q + PTR_W'(1));
    end

    // When full, lu_ready is already low, so a same-cycle pop cannot make
    // room for this enqueue; the freed slot is visible next cycle.
    if (enq_c) begin
      mem_d[tail_idx_c] = '{waddr: lu_waddr, wdata: lu_wdata, pc: lu_pc};
      tail_d            = PTR_W'(tail_q + PTR_W'(1));
    end

    // Counts consecutive cycles the head loses to write-back.
    if (fifo_grant_c || !fifo_req_c) begin
      starve_cnt_d = '0;
    end else if (wb_grant_c && !starved_c) begin
      starve_cnt_d = CNT_W'(starve_cnt_q + CNT_W'(1));
    end
  end

  // ---------------------------------------------------------------------
  // Pending-write lookup over occupied entries (includes one being popped)
  // ---------------------------------------------------------------------
  logic [4:0]        q_addr_c [NQUERY];
  logic [NQUERY-1:0] q_pend_c;

  assign q_addr_c[0] = q0_addr;
  assign q_addr_c[1] = q1_addr;
  assign q_addr_c[2] = q2_addr;

  always_comb begin
    q_pend_c = '0;
    for (int q = 0; q < int'(NQUERY); q++) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        if ((PTR_W'(i) < occupancy_c) && (q_addr_c[q] != 5'd0) &&
            (mem_q[IDX_W'(head_q + PTR_W'(i))].waddr == q_addr_c[q])) begin
          q_pend_c[q] = 1'b1;
        end
      end
    end
  end

  assign q0_pend = q_pend_c[0];
  assign q1_pend = q_pend_c[1];
  assign q2_pend = q_pend_c[2];

  // ---------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head_q       <= '0;
      tail_q       <= '0;
      starve_cnt_q <= '0;
    end else begin
      head_q       <= head_d;
      tail_q       <= tail_d;
      starve_cnt_q <= starve_cnt_d;
    end
  end

  // Payload storage needs no reset: occupancy is tracked by the pointers.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: doc/rf_wport_arbiter.md
# rf_wport_arbiter

Shares the single register-file write port between the in-order write-back stage and a long-latency result source (divider / refill return) that completes out of pipeline order. Long-latency results are buffered in a small FIFO and drained on cycles where write-back does not use the port. A starvation guard briefly holds write-back so buffered results always retire. Pending-write lookups let decode stall on RAW/WAW hazards against buffered results.

## Interface
- `DEPTH`, 2: long-latency FIFO entries, ≥2, power of two.
- `STARVE_LIMIT`, 4: consecutive cycles a non-empty FIFO may be denied before write-back is held, ≥1.
- `clk` in 1: clock, all state on rising edge.
- `reset` in 1: asynchronous, active-high; clears all state.
- `wb_we` in 1: write-back stage write request (already qualified by stage valid).
- `wb_waddr` in 5: write-back destination register.
- `wb_wdata` in 32: write-back data.
- `wb_pc` in 32: write-back PC, for trace.
- `wb_hold` out 1: port taken by FIFO this cycle; write-back must keep its entry and inputs stable.
- `lu_valid` in 1: long-latency result offered.
- `lu_ready` out 1: FIFO can accept this cycle.
- `lu_waddr` in 5, `lu_wdata` in 32, `lu_pc` in 32: long-latency result fields.
- `rf_we` out 1, `rf_waddr` out 5, `rf_wdata` out 32: register-file write port.
- `rf_pc` out 32: PC of the retiring write, for debug trace.
- `q0_addr`, `q1_addr`, `q2_addr` in 5 each: decode query addresses (rs1, rs2, rd).
- `q0_pend`, `q1_pend`, `q2_pend` out 1 each: a buffered write to that register is outstanding.

## Operation
- Effective requests: `wb_req = wb_we && wb_waddr != 0`; `fifo_req = FIFO non-empty`.
- Accept: when `lu_valid && lu_ready`, enqueue {waddr, wdata, pc} at tail. If `lu_waddr == 0`, the handshake completes but nothing is enqueued.
- `lu_ready = !full`. It depends only on registered state, never on `lu_valid`.
- Grant, evaluated every cycle:
  - FIFO is granted if `fifo_req && (!wb_req || starve_cnt == STARVE_LIMIT)`.
  - Otherwise write-back is granted if `wb_req`.
  - Otherwise the port is idle.
- FIFO grant pops the head and drives the port from the head entry. `wb_hold = fifo_grant && wb_req`.
- Write-back grant drives the port from `wb_*`. Writes to register 0 never assert `rf_we`.
- `starve_cnt`:
  - Increments when `fifo_req && wb grant`.
  - Clears on FIFO grant or when the FIFO is empty.
  - Saturates at `STARVE_LIMIT`.
- Pending lookup: `qN_pend = 1` iff `qN_addr != 0` and any occupied FIFO entry has `waddr == qN_addr`.
  - An entry popped this cycle still reports a hit; the lookup is conservative.
  - An entry enqueued this cycle does not report until the next cycle.
- Enqueue and pop in the same cycle are both legal, including when full: pop frees a slot next cycle only, because `lu_ready` is already 0 when full.
- Pointers are `log2(DEPTH)+1` bits wrapping modulo `2*DEPTH`.
  - Full: MSBs differ and the remaining bits are equal.
  - Empty: the pointers are equal.

## Timing
- Reset values:
  - `rf_we`=0, `wb_hold`=0, `lu_ready`=1, all `qN_pend`=0.
  - FIFO empty, `starve_cnt`=0.
  - `rf_waddr`/`rf_wdata`/`rf_pc` are don't-care while `rf_we`=0.
- Write-back path is combinational, zero latency: `rf_*` follow `wb_*` in the same cycle.
- Long-latency path: a result accepted in cycle N retires no earlier than cycle N+1. Results retire in acceptance order.
- Worst-case FIFO head wait under continuous write-back: `STARVE_LIMIT` cycles. The hold lasts exactly 1 cycle per retired entry.
- `wb_hold` is combinational from registered state and `wb_we`/`wb_waddr`.
- Reset asserted mid-operation discards all buffered entries immediately (asynchronous). No write is performed after reset assertion.

## Test plan
- Reset: assert `reset` with `lu_valid`=1 and `wb_we`=1 → `rf_we`=0 and `lu_ready`=1 during reset. After release, a write-back of x5=0x11 appears on the port the same cycle.
- Lone long-latency result: `lu_valid` with x7=0xABCD, no write-back.
  - `q*_addr`=7 reports pend=1 from cycle N+1.
  - In cycle N+1, `rf_we`=1, `rf_waddr`=7, `rf_wdata`=0xABCD.
  - pend=0 in cycle N+2.
- Contention and starvation: enqueue x3; drive write-back every cycle to x4.
  - 4 cycles of x4 writes with `wb_hold`=0.
  - 5th cycle: `rf_waddr`=3 with `wb_hold`=1.
  - 6th cycle: the held x4 write retires.
- Backpressure: enqueue 2 entries while write-back is busy → `lu_ready`=0. A third `lu_valid` is not accepted until after a pop. Retire order is x1, x2, x3.
- Register 0: `lu_valid` with x0 → handshake completes, FIFO stays empty, pend stays 0. `wb_we` to x0 → `rf_we`=0, and a pending FIFO entry drains that cycle.
- Reset mid-operation: 2 entries queued, assert `reset` → next cycle `rf_we`=0, all pend=0, `lu_ready`=1.
